// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer for the 6502C core.
// Synchronizes the NMI_L and IRQ_L pins and latches NMI falling edges.
// Arbitrates RES, NMI, IRQ and BRK at instruction boundaries.
// Runs the seven-step entry sequence: two dummy cycles, three stack pushes,
// then the two vector fetches that also set the I flag.
// Every output is a flop except the stall-gated strobes, which are decoded
// from the current step and qualified by rdy.

module interrupt_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RES_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        NMI_L,
  input  logic        IRQ_L,
  input  logic        brk_req,
  input  logic        I_flag,
  input  logic        instr_end,
  input  logic        rdy,
  output logic        seq_active,
  output logic [2:0]  seq_step,
  output logic [1:0]  int_src,
  output logic        push_en,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic [15:0] vec_addr,
  output logic        vec_rd_lo,
  output logic        vec_rd_hi,
  output logic        set_I,
  output logic        seq_done,
  output logic        nmi_pending
);

  // The step number is the state encoding itself, so seq_step can be taken
  // straight from the next-state value; IDLE sits in the unused code 7.
  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6,
    ST_IDLE = 3'd7
  } state_t;

  // Interrupt source codes, as they appear on int_src.
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_RES  = 2'b01,
    SRC_NMI  = 2'b10,
    SRC_IRQ  = 2'b11
  } src_t;

  logic [SYNC_STAGES-1:0] nmi_sync;
  logic [SYNC_STAGES-1:0] irq_sync;
  logic                   nmi_s;
  logic                   irq_s;
  logic                   nmi_prev;
  logic                   nmi_edge;
  logic                   irq_req;
  logic                   res_pending;

  state_t                 state;
  state_t                 state_nx;
  src_t                   src;
  src_t                   src_nx;
  logic                   is_brk;
  logic                   is_brk_nx;
  logic [15:0]            base;
  logic [15:0]            base_nx;
  logic [2:0]             step_nx;
  logic                   nmi_clr;
  logic                   res_clr;

  assign nmi_s    = nmi_sync[SYNC_STAGES-1];
  assign irq_s    = irq_sync[SYNC_STAGES-1];
  assign nmi_edge = nmi_prev & ~nmi_s;
  assign irq_req  = ~irq_s & ~I_flag;
  assign int_src  = src;
  assign step_nx  = state_nx;

  // Shift both asynchronous pins through their synchronizer chains.
  // The chains idle high, so reset must not look like a pin going low.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      nmi_sync <= '1;
      irq_sync <= '1;
    end else begin
      nmi_sync[0] <= NMI_L;
      irq_sync[0] <= IRQ_L;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nmi_sync[i] <= nmi_sync[i-1];
        irq_sync[i] <= irq_sync[i-1];
      end
    end
  end

  // Latch NMI falling edges and the power-on reset request.
  // A new edge wins over the clear, so an NMI arriving at that moment is kept.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
      res_pending <= 1'b1;
    end else begin
      nmi_prev <= nmi_s;
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end else if (nmi_clr) begin
        nmi_pending <= 1'b0;
      end
      if (res_clr) begin
        res_pending <= 1'b0;
      end
    end
  end

  // Decide the next state, the source and the vector base for the sequence.
  // The sequence is never re-entered from S6. Any request still pending at
  // that point waits in IDLE for the next instruction boundary.
  always_comb begin
    state_nx  = state;
    src_nx    = src;
    is_brk_nx = is_brk;
    base_nx   = base;
    nmi_clr   = 1'b0;
    res_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        src_nx    = SRC_NONE;
        is_brk_nx = 1'b0;
        if (res_pending) begin
          state_nx = ST_S0;
          src_nx   = SRC_RES;
        end else if (instr_end && rdy) begin
          if (nmi_pending) begin
            state_nx = ST_S0;
            src_nx   = SRC_NMI;
          end else if (irq_req) begin
            state_nx = ST_S0;
            src_nx   = SRC_IRQ;
          end else if (brk_req) begin
            state_nx  = ST_S0;
            src_nx    = SRC_IRQ;
            is_brk_nx = 1'b1;
          end
        end
      end
      ST_S6: begin
        if (rdy) begin
          state_nx  = ST_IDLE;
          src_nx    = SRC_NONE;
          is_brk_nx = 1'b0;
          res_clr   = (src == SRC_RES);
        end
      end
      default: begin
        if (rdy) begin
          state_nx = state_t'(state + 3'd1);
          // The vector is chosen while leaving S4. A pending NMI takes over
          // an IRQ/BRK sequence here; the P byte is already on the stack.
          if (state == ST_S4) begin
            case (src)
              SRC_RES: base_nx = RES_VEC;
              SRC_NMI: base_nx = NMI_VEC;
              default: begin
                if (nmi_pending) begin
                  base_nx = NMI_VEC;
                  src_nx  = SRC_NMI;
                end else begin
                  base_nx = IRQ_VEC;
                end
              end
            endcase
          end
          nmi_clr = (state == ST_S5) && (src == SRC_NMI);
        end
      end
    endcase
  end

  // Register the state together with the step-dependent outputs. They are
  // computed from the next state so that they line up with the current step.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state      <= ST_IDLE;
      src        <= SRC_NONE;
      is_brk     <= 1'b0;
      base       <= '0;
      seq_active <= 1'b0;
      seq_step   <= 3'd0;
      push_sel   <= 2'b00;
      b_flag     <= 1'b0;
      vec_addr   <= '0;
    end else begin
      state      <= state_nx;
      src        <= src_nx;
      is_brk     <= is_brk_nx;
      base       <= base_nx;
      seq_active <= (state_nx != ST_IDLE);
      seq_step   <= (state_nx == ST_IDLE) ? 3'd0 : step_nx;
      case (state_nx)
        ST_S3:   push_sel <= 2'b01;
        ST_S4:   push_sel <= 2'b10;
        default: push_sel <= 2'b00;
      endcase
      b_flag <= (state_nx == ST_S4) && is_brk_nx;
      case (state_nx)
        ST_S5:   vec_addr <= base_nx;
        ST_S6:   vec_addr <= 16'(base_nx + 16'd1);
        default: vec_addr <= '0;
      endcase
    end
  end

  // Strobes fire only while rdy is high. A reset sequence performs dummy
  // stack reads, so it never raises push_en.
  always_comb begin
    push_en   = 1'b0;
    vec_rd_lo = 1'b0;
    vec_rd_hi = 1'b0;
    set_I     = 1'b0;
    seq_done  = 1'b0;
    if (rdy) begin
      case (state)
        ST_S2, ST_S3, ST_S4: push_en = (src != SRC_RES);
        ST_S5:               vec_rd_lo = 1'b1;
        ST_S6: begin
          vec_rd_hi = 1'b1;
          set_I     = 1'b1;
          seq_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // At most one datapath access strobe is active in any cycle.
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_L)
    $onehot0({push_en, vec_rd_lo, vec_rd_hi}));

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus a
// randomized request mix, all compared against a step-level model.

module tb_interrupt_sequencer;

  localparam int K_RES  = 0;
  localparam int K_NMI  = 1;
  localparam int K_IRQ  = 2;
  localparam int K_BRK  = 3;
  localparam int K_NONE = 4;

  typedef struct packed {
    logic        active;
    logic [2:0]  step;
    logic [1:0]  src;
    logic        push;
    logic [1:0]  psel;
    logic        b;
    logic [15:0] vaddr;
    logic        lo;
    logic        hi;
    logic        seti;
    logic        done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_L, NMI_L, IRQ_L, brk_req, I_flag, instr_end, rdy;
  logic        seq_active, push_en, b_flag, vec_rd_lo, vec_rd_hi;
  logic        set_I, seq_done, nmi_pending;
  logic [2:0]  seq_step;
  logic [1:0]  int_src, push_sel;
  logic [15:0] vec_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_sequencer dut (
    .clk(clk), .rst_L(rst_L), .NMI_L(NMI_L), .IRQ_L(IRQ_L),
    .brk_req(brk_req), .I_flag(I_flag), .instr_end(instr_end), .rdy(rdy),
    .seq_active(seq_active), .seq_step(seq_step), .int_src(int_src),
    .push_en(push_en), .push_sel(push_sel), .b_flag(b_flag),
    .vec_addr(vec_addr), .vec_rd_lo(vec_rd_lo), .vec_rd_hi(vec_rd_hi),
    .set_I(set_I), .seq_done(seq_done), .nmi_pending(nmi_pending)
  );

  // Expected outputs of one step of an interrupt entry sequence.
  function automatic obs_t model_step(int s, int kind, bit hijack, bit rdy_now);
    obs_t        o;
    logic [15:0] vbase;
    o = '0;
    if (kind == K_NONE || s > 6) return o;
    o.active = 1'b1;
    o.step   = 3'(s);
    if (kind == K_RES)                    o.src = 2'b01;
    else if (kind == K_NMI)               o.src = 2'b10;
    else if (hijack && s >= 5)            o.src = 2'b10;
    else                                  o.src = 2'b11;
    o.psel = (s == 3) ? 2'b01 : (s == 4) ? 2'b10 : 2'b00;
    o.b    = (s == 4) && (kind == K_BRK);
    if (kind == K_RES)                    vbase = 16'hFFFC;
    else if (kind == K_NMI || hijack)     vbase = 16'hFFFA;
    else                                  vbase = 16'hFFFE;
    if (s == 5) o.vaddr = vbase;
    if (s == 6) o.vaddr = vbase + 16'd1;
    if (rdy_now) begin
      o.push = (s >= 2) && (s <= 4) && (kind != K_RES);
      o.lo   = (s == 5);
      o.hi   = (s == 6);
      o.seti = (s == 6);
      o.done = (s == 6);
    end
    return o;
  endfunction

  function automatic obs_t observe();
    return {seq_active, seq_step, int_src, push_en, push_sel, b_flag,
            vec_addr, vec_rd_lo, vec_rd_hi, set_I, seq_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    rst_L = 1'b0; NMI_L = 1'b1; IRQ_L = 1'b1; brk_req = 1'b0;
    I_flag = 1'b1; instr_end = 1'b0; rdy = 1'b1;
    repeat (3) tick();
    got = observe(); want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("[TB] FAIL reset_outputs got=%h want=%h", got, want);
    end
    n_checks++;
    if (nmi_pending !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_nmi_pending got=%b want=0", nmi_pending);
    end
    rst_L = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      got = observe(); want = model_step(s, K_RES, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL res_step%0d got=%h want=%h", s, got, want);
      end
    end
  endtask

  task automatic test_nmi();
    obs_t got, want;
    NMI_L = 1'b0;
    tick();
    NMI_L = 1'b1;
    n_checks++;
    if (nmi_pending !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nmi_early1 got=%b want=0", nmi_pending);
    end
    tick();
    n_checks++;
    if (nmi_pending !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nmi_early2 got=%b want=0", nmi_pending);
    end
    tick();
    n_checks++;
    if (nmi_pending !== 1'b1) begin
      n_fail++; $display("[TB] FAIL nmi_latched got=%b want=1", nmi_pending);
    end
    instr_end = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      if (s == 0) instr_end = 1'b0;
      got = observe(); want = model_step(s, K_NMI, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL nmi_step%0d got=%h want=%h", s, got, want);
      end
      n_checks++;
      if (nmi_pending !== (s <= 5)) begin
        n_fail++; $display("[TB] FAIL nmi_pend_step%0d got=%b want=%b", s, nmi_pending, (s <= 5));
      end
    end
  endtask

  task automatic test_irq();
    obs_t got, want;
    IRQ_L = 1'b0; I_flag = 1'b1;
    repeat (3) tick();
    instr_end = 1'b1;
    tick();
    instr_end = 1'b0;
    got = observe(); want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("[TB] FAIL irq_masked got=%h want=%h", got, want);
    end
    I_flag = 1'b0; instr_end = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      if (s == 0) begin instr_end = 1'b0; IRQ_L = 1'b1; end
      got = observe(); want = model_step(s, K_IRQ, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL irq_step%0d got=%h want=%h", s, got, want);
      end
    end
    I_flag = 1'b1;
  endtask

  task automatic test_brk();
    obs_t got, want;
    brk_req = 1'b1; instr_end = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      if (s == 0) begin brk_req = 1'b0; instr_end = 1'b0; end
      got = observe(); want = model_step(s, K_BRK, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL brk_step%0d got=%h want=%h", s, got, want);
      end
    end
  endtask

  task automatic test_hijack();
    obs_t got, want;
    brk_req = 1'b1; instr_end = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      if (s == 0) begin brk_req = 1'b0; instr_end = 1'b0; NMI_L = 1'b0; end
      if (s == 1) NMI_L = 1'b1;
      got = observe(); want = model_step(s, K_BRK, 1'b1, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL hijack_step%0d got=%h want=%h", s, got, want);
      end
      if (s == 3) begin
        n_checks++;
        if (nmi_pending !== 1'b1) begin
          n_fail++; $display("[TB] FAIL hijack_pend_s3 got=%b want=1", nmi_pending);
        end
      end
    end
    n_checks++;
    if (nmi_pending !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hijack_pend_after got=%b want=0", nmi_pending);
    end
    instr_end = 1'b1;
    tick();
    instr_end = 1'b0;
    got = observe(); want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("[TB] FAIL hijack_no_replay got=%h want=%h", got, want);
    end
  endtask

  task automatic test_nmi_held();
    int dones;
    dones = 0;
    NMI_L = 1'b0; instr_end = 1'b1;
    repeat (50) begin
      tick();
      if (seq_done === 1'b1) dones++;
    end
    NMI_L = 1'b1;
    repeat (10) begin
      tick();
      if (seq_done === 1'b1) dones++;
    end
    instr_end = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("[TB] FAIL nmi_held_sequences got=%0d want=1", dones);
    end
    n_checks++;
    if (nmi_pending !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nmi_held_pend got=%b want=0", nmi_pending);
    end
  endtask

  task automatic test_rdy_stall();
    obs_t got, want;
    int   pcl;
    pcl = 0;
    brk_req = 1'b1; instr_end = 1'b1;
    for (int s = 0; s <= 3; s++) begin
      tick();
      if (s == 0) begin brk_req = 1'b0; instr_end = 1'b0; end
      got = observe(); want = model_step(s, K_BRK, 1'b0, 1'b1);
      if (s < 3) begin
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("[TB] FAIL stall_pre%0d got=%h want=%h", s, got, want);
        end
        if (got.push && got.psel == 2'b01) pcl++;
      end
    end
    rdy = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      got = observe(); want = model_step(3, K_BRK, 1'b0, 1'b0);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL stall_hold%0d got=%h want=%h", c, got, want);
      end
      if (got.push && got.psel == 2'b01) pcl++;
    end
    rdy = 1'b1;
    #1;
    for (int s = 3; s <= 7; s++) begin
      if (s > 3) tick();
      got = observe(); want = model_step(s, K_BRK, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL stall_post%0d got=%h want=%h", s, got, want);
      end
      if (got.push && got.psel == 2'b01) pcl++;
    end
    n_checks++;
    if (pcl != 1) begin
      n_fail++; $display("[TB] FAIL stall_pcl_pushes got=%0d want=1", pcl);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    brk_req = 1'b1; instr_end = 1'b1;
    for (int s = 0; s <= 4; s++) begin
      tick();
      if (s == 0) begin brk_req = 1'b0; instr_end = 1'b0; end
      got = observe(); want = model_step(s, K_BRK, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL abort_pre%0d got=%h want=%h", s, got, want);
      end
    end
    rst_L = 1'b0;
    tick();
    got = observe(); want = '0;
    n_checks++;
    if (got !== want) begin
      n_fail++; $display("[TB] FAIL abort_outputs got=%h want=%h", got, want);
    end
    rst_L = 1'b1;
    for (int s = 0; s <= 7; s++) begin
      tick();
      got = observe(); want = model_step(s, K_RES, 1'b0, 1'b1);
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("[TB] FAIL abort_res%0d got=%h want=%h", s, got, want);
      end
    end
  endtask

  task automatic test_random();
    obs_t got, want;
    bit   nmi, irq, mask, brk, r;
    int   kind, s, guard;
    for (int it = 0; it < 24; it++) begin
      nmi  = 1'($urandom_range(0, 1));
      irq  = 1'($urandom_range(0, 1));
      mask = 1'($urandom_range(0, 1));
      brk  = 1'($urandom_range(0, 1));
      rdy  = 1'b1;
      if (nmi) begin
        NMI_L = 1'b0;
        tick();
        NMI_L = 1'b1;
        tick();
        tick();
        n_checks++;
        if (nmi_pending !== 1'b1) begin
          n_fail++; $display("[TB] FAIL rand%0d_pend got=%b want=1", it, nmi_pending);
        end
      end
      IRQ_L  = ~irq;
      I_flag = mask;
      repeat (3) tick();
      if (nmi)                kind = K_NMI;
      else if (irq && !mask)  kind = K_IRQ;
      else if (brk)           kind = K_BRK;
      else                    kind = K_NONE;
      instr_end = 1'b1; brk_req = brk;
      tick();
      instr_end = 1'b0; brk_req = 1'b0; IRQ_L = 1'b1;
      s = 0;
      guard = 0;
      if (kind == K_NONE) begin
        got = observe(); want = '0;
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("[TB] FAIL rand%0d_idle got=%h want=%h", it, got, want);
        end
      end else begin
        while (s <= 6 && guard < 60) begin
          r   = ($urandom_range(0, 3) != 0);
          rdy = r;
          #1;
          got = observe(); want = model_step(s, kind, 1'b0, r);
          n_checks++;
          if (got !== want) begin
            n_fail++; $display("[TB] FAIL rand%0d_step%0d got=%h want=%h", it, s, got, want);
          end
          tick();
          if (r) s++;
          guard++;
        end
        if (s <= 6) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL rand%0d_timeout got=step%0d want=step7", it, s);
        end
        rdy = 1'b1;
        #1;
        got = observe(); want = '0;
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("[TB] FAIL rand%0d_end got=%h want=%h", it, got, want);
        end
      end
      n_checks++;
      if (nmi_pending !== 1'b0) begin
        n_fail++; $display("[TB] FAIL rand%0d_pend_end got=%b want=0", it, nmi_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_irq();
    test_brk();
    test_hijack();
    test_nmi_held();
    test_rdy_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
